// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: fetches operand pairs and drives the shared multi-cycle
// multiplier and adder through req/ack handshakes, accumulating sum(x[i]*w[i]).
module mac_seq_ctrl #(
  parameter int N_MAX   = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       count,
  output logic             op_rd,
  output logic [IDX_W-1:0] op_addr,
  input  logic [7:0]       x_data,
  input  logic [7:0]       w_data,
  output logic             mul_req,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic             mul_ack,
  input  logic [15:0]      mul_p,
  output logic             add_req,
  output logic [15:0]      add_x,
  output logic [15:0]      add_y,
  input  logic             add_ack,
  input  logic [15:0]      add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output logic             ovf,
  output logic             err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  // DROP is the one idle cycle between the multiplier and adder handshakes
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_MUL, S_DROP, S_ADD, S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W:0]   cnt, count_cl;
  logic [IDX_W-1:0] idx;
  logic [15:0]      acc, prod;
  logic [TW-1:0]    wait_cnt;
  logic             start_ok, mul_hit, add_hit, tmo, last;

  always_comb begin
    count_cl = (int'(count) > N_MAX) ? (IDX_W+1)'(N_MAX) : count[IDX_W:0];
    // a start landing on the done cycle is deliberately dropped
    start_ok = (state == S_IDLE) && start && !done;
    mul_hit  = (state == S_MUL) && mul_ack;
    add_hit  = (state == S_ADD) && add_ack;
    tmo      = (((state == S_MUL) && !mul_ack) || ((state == S_ADD) && !add_ack)) &&
               (wait_cnt == TW'(TIMEOUT - 1));
    last     = (({1'b0, idx} + 1'b1) == cnt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_ok) state_nxt = (count_cl == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_MUL;
      S_MUL:    if (mul_ack) state_nxt = S_DROP;
                else if (tmo) state_nxt = S_FINISH;
      S_DROP:   state_nxt = S_ADD;
      S_ADD:    if (add_ack) state_nxt = last ? S_FINISH : S_FETCH;
                else if (tmo) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      acc      <= '0;
      prod     <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      wait_cnt <= '0;
      result   <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_FINISH);
      // MUL is entered only from LOAD and ADD only from DROP, so the count restarts at 0
      wait_cnt <= ((state == S_MUL) || (state == S_ADD)) ? wait_cnt + 1'b1 : '0;
      if (start_ok) begin
        cnt <= count_cl;
        idx <= '0;
        acc <= '0;
        ovf <= 1'b0;
        err <= 1'b0;
      end
      if (state == S_LOAD) begin
        mul_a <= x_data;
        mul_b <= w_data;
      end
      if (mul_hit) prod <= mul_p;
      if (add_hit) begin
        acc <= add_sum;
        ovf <= ovf | add_cout;
        idx <= idx + 1'b1;
      end
      if (tmo) err <= 1'b1;
      if (state == S_FINISH) result <= acc;
    end
  end

  assign op_rd   = (state == S_FETCH);
  assign op_addr = idx;
  assign mul_req = (state == S_MUL);
  assign add_req = (state == S_ADD);
  assign add_x   = prod;
  assign add_y   = acc;
  assign busy    = (state != S_IDLE);
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: table of jobs against a latency-programmable
// mul/add model, plus timeout, mid-job reset and held-start sequences.
module tb_mac_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  count;
  logic        op_rd;
  logic [2:0]  op_addr;
  logic [7:0]  x_data, w_data;
  logic        mul_req, mul_ack;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic        add_req, add_ack, add_cout;
  logic [15:0] add_x, add_y, add_sum;
  logic        busy, done, ovf, err;
  logic [15:0] result;

  mac_seq_ctrl #(.N_MAX(8), .IDX_W(3), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .op_rd(op_rd), .op_addr(op_addr), .x_data(x_data), .w_data(w_data),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_p(mul_p),
    .add_req(add_req), .add_x(add_x), .add_y(add_y), .add_ack(add_ack),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // operand buffers and datapath model
  logic [7:0] x_mem [8];
  logic [7:0] w_mem [8];
  int         lat;
  logic       mul_en, spur;
  int         mul_wait, add_wait;

  always @(posedge clk) begin
    if (op_rd) begin
      x_data <= x_mem[op_addr];
      w_data <= w_mem[op_addr];
    end
    mul_wait <= (!mul_req || mul_ack) ? 0 : mul_wait + 1;
    add_wait <= (!add_req || add_ack) ? 0 : add_wait + 1;
  end

  assign mul_p   = 16'(mul_a) * 16'(mul_b);
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y};
  assign mul_ack = (mul_req && mul_en && mul_wait == lat) || (spur && !busy);
  assign add_ack = (add_req && add_wait == lat) || (spur && !busy);

  // running totals; tasks take deltas
  int n_rd = 0, n_addr_err = 0, n_mreq = 0, n_areq = 0, n_done = 0, next_addr = 0;
  always @(negedge clk) begin
    if (op_rd) n_rd <= n_rd + 1;
    if (mul_req) n_mreq <= n_mreq + 1;
    if (add_req) n_areq <= n_areq + 1;
    if (done) n_done <= n_done + 1;
    if (!busy) next_addr <= 0;
    else if (op_rd) begin
      if (int'(op_addr) != next_addr) n_addr_err <= n_addr_err + 1;
      next_addr <= next_addr + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]      cnt;
    logic [7:0][7:0] x;
    logic [7:0][7:0] w;
    int              lat;
    logic [15:0]     res;
    logic            ovf;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] c, input logic [63:0] x, input logic [63:0] w,
                              input int l, input logic [15:0] r, input logic o);
    vec_t v;
    v.cnt = c; v.x = x; v.w = w; v.lat = l; v.res = r; v.ovf = o;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      x_mem[i] = v.x[i];
      w_mem[i] = v.w[i];
    end
    lat = v.lat;
  endtask

  task automatic run_job(input string tag, input vec_t v);
    int n, cyc, rd0, ae0, mr0, ar0, dn0;
    n = (v.cnt > 8) ? 8 : int'(v.cnt);
    load(v);
    rd0 = n_rd; ae0 = n_addr_err; mr0 = n_mreq; ar0 = n_areq; dn0 = n_done;
    start = 1'b1; count = v.cnt;
    cyc = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) break;
    end
    chk({tag, " cycles"}, cyc, n * (5 + 2 * v.lat) + 2);
    chk({tag, " result"}, result, v.res);
    chk({tag, " ovf"}, ovf, v.ovf);
    chk({tag, " err"}, err, 0);
    chk({tag, " op_rd"}, n_rd - rd0, n);
    chk({tag, " addr"}, n_addr_err - ae0, 0);
    chk({tag, " mul_req cyc"}, n_mreq - mr0, n * (v.lat + 1));
    chk({tag, " add_req cyc"}, n_areq - ar0, n * (v.lat + 1));
    @(negedge clk);
    chk({tag, " one done"}, n_done - dn0, 1);
    chk({tag, " done low"}, done, 0);
    chk({tag, " result held"}, result, v.res);
  endtask

  task automatic chk_zero(input string name);
    chk(name, ({op_rd, op_addr, mul_req, mul_a, mul_b, add_req, add_x, add_y,
                busy, done, result, ovf, err} == '0) ? 1 : 0, 1);
  endtask

  vec_t vecs [6];

  initial begin
    vec_t v;
    int   run, dn0, prev, per_bad, res_bad, rd0, ndone;

    vecs[0] = mk(4'd3,  64'h030201, 64'h020202, 2, 16'd12, 1'b0);
    vecs[1] = mk(4'd8,  {8{8'hFF}}, {8{8'hFF}}, 0, 16'd61448, 1'b1);
    vecs[2] = mk(4'd0,  64'h0, 64'h0, 0, 16'd0, 1'b0);
    vecs[3] = mk(4'd12, 64'h0807060504030201, 64'h0101010101010101, 0, 16'd36, 1'b0);
    vecs[4] = mk(4'd2,  64'h64C8, 64'h64C8, 1, 16'd50000, 1'b0);
    vecs[5] = mk(4'd2,  64'hC8C8, 64'hC8C8, 0, 16'd14464, 1'b1);

    reset = 1'b1; start = 1'b0; count = '0; mul_en = 1'b1; spur = 1'b0; lat = 0;
    x_data = '0; w_data = '0; mul_wait = 0; add_wait = 0;
    for (int i = 0; i < 8; i++) begin x_mem[i] = '0; w_mem[i] = '0; end
    repeat (3) @(negedge clk);
    chk_zero("reset outputs");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job($sformatf("vec%0d", i), vecs[i]);

    // multiplier never acks the second pair
    v = mk(4'd3, 64'h060504, 64'h030303, 0, 16'd12, 1'b0);
    load(v);
    start = 1'b1; count = v.cnt;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (add_req && add_ack) break;
      @(negedge clk);
    end
    mul_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mul_req) break;
      @(negedge clk);
    end
    run = 0;
    for (int k = 0; k < 40; k++) begin
      if (!mul_req) break;
      run++;
      @(negedge clk);
    end
    chk("timeout mul_req run", run, 15);
    @(negedge clk);
    chk("timeout done", done, 1);
    chk("timeout err", err, 1);
    chk("timeout result", result, 16'd12);
    chk("timeout ovf", ovf, 0);
    mul_en = 1'b1;
    @(negedge clk);

    run_job("after timeout", vecs[0]);

    // reset while the adder handshake is pending
    v = mk(4'd2, 64'h0202, 64'h0303, 3, 16'd0, 1'b0);
    load(v);
    start = 1'b1; count = v.cnt;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (add_req) break;
      @(negedge clk);
    end
    chk("reached ADD", add_req, 1);
    dn0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid-job reset outputs");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("no done after reset", n_done - dn0, 0);
    run_job("post reset", mk(4'd1, 64'h05, 64'h07, 0, 16'd35, 1'b0));

    // start held high, spurious acks whenever idle
    load(mk(4'd1, 64'h05, 64'h07, 0, 16'd35, 1'b0));
    spur = 1'b1; start = 1'b1; count = 4'd1;
    rd0 = n_rd; dn0 = n_done;
    prev = -1; per_bad = 0; res_bad = 0; ndone = 0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (ndone > 0 && result !== 16'd35) res_bad++;
      if (done) begin
        if (busy) per_bad++;
        if (prev >= 0 && k - prev != 8) per_bad++;
        prev = k;
        ndone++;
      end
    end
    start = 1'b0; spur = 1'b0;
    chk("held start dones", ndone, 6);
    chk("held start period", per_bad, 0);
    chk("held start result", res_bad, 0);
    chk("held start ovf", ovf, 0);
    chk("held start one job per idle", ((n_rd - rd0) - (n_done - dn0) inside {0, 1}) ? 1 : 0, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy && !done) break;
    end
    chk("settled idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
